irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt aggregator on the demo-system device bus, 4 KiB slot at 0x80005000.
- Latches up to NumSrc peripheral interrupt lines: level or edge, per-source enable, claim/complete handshake.
- Drives one request into the Ibex irq_external_i.
- Register-read latency of 1 cycle, the same as the other bus devices.

Parameters:
- NumSrc, 8, number of interrupt sources; legal range 1..31; source IDs are 1..NumSrc.
- AddrWidth, 32, width of device_addr_i.
- DataWidth, 32, bus data width; fixed at 32.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; one clock; reset is asynchronous and active-high
- device_req_i  input  1  bus request; single-cycle, always accepted
- device_addr_i  input  AddrWidth  byte address; only bits [4:2] are decoded
- device_we_i  input  1  write enable
- device_be_i  input  4  byte enables
- device_wdata_i  input  32  write data
- device_rvalid_o  output  1  response valid, one cycle after every request (reads and writes)
- device_rdata_o  output  32  read data; 0 for writes and unmapped offsets
- irq_src_i  input  NumSrc  interrupt source lines, synchronous to clk_i; bit i is ID i+1
- irq_o  output  1  aggregated request to the core

Behaviour:
- Reset values (rst_i high, asynchronous): pending, enable, edge_sel, in_service, src_q are all 0; irq_o=0; device_rvalid_o=0; device_rdata_o=0.

Register map (offset = addr[4:2]*4):
- 0x00 PENDING: read-only; writes are ignored.
- 0x04 ENABLE: read/write.
- 0x08 EDGE_SEL: read/write; 1 = edge-triggered, 0 = level.
- 0x0C CLAIM: read = claim; write = complete.
- 0x10 IN_SERVICE: read-only.
- Other offsets: read 0, writes ignored.
- Writes honour device_be_i per byte. Bits at or above NumSrc read 0 and ignore writes.

Source capture, every cycle:
- src_q <= irq_src_i.
- Edge source: pending[i] set when irq_src_i[i] & ~src_q[i]. It stays set until claimed.
- Level source: pending[i] <= irq_src_i[i] (registered copy).
- Changing EDGE_SEL for source i clears pending[i] in the same cycle.

Claim (read of 0x0C):
- Returns the lowest ID with pending & enable & ~in_service, or 0 if none.
- In the request cycle, for the claimed ID: in_service bit is set; pending bit is cleared if the source is edge-triggered.
- If a new rising edge on the same source lands in the claim cycle, pending stays 1 (the new event wins).

Complete (write to 0x0C with device_be_i[0]=1):
- wdata[4:0] = ID; clears in_service[ID-1].
- ID 0, ID > NumSrc, or an ID not in service: no effect.
- Claim and complete cannot coincide, because there is only one request per cycle.

irq_o:
- irq_o <= |(pending & enable & ~in_service), registered.
- Latency: an edge sampled at clock k sets pending after k; irq_o rises after k+1.
- After a claim read at clock k, irq_o reflects the updated state after k+1.

Bus response:
- device_rvalid_o <= device_req_i.
- device_rdata_o <= read value when device_req_i & ~device_we_i, else 0.
- No wait states, no error response.

Reset mid-operation: all state, including in_service, clears immediately; a pending claim response is dropped (device_rvalid_o forced to 0).

Test Plan:
- Reset, then read all five offsets -> each returns 0; device_rvalid_o asserts exactly one cycle after each request; irq_o=0.
- ENABLE=0x04, EDGE_SEL=0x04, pulse irq_src_i[2] for one cycle -> PENDING=0x04; irq_o=1 two cycles after the edge; CLAIM read returns 3; PENDING=0; IN_SERVICE=0x04; irq_o falls; write 3 to CLAIM -> IN_SERVICE=0.
- ENABLE=0x03, level sources, hold irq_src_i[0] and [1] high -> claims return 1 then 2; a third claim returns 0; complete 1 with src[0] still high -> irq_o reasserts and the next claim returns 1.
- Edge source 1 claimed in the same cycle as a new rising edge on src[0] -> CLAIM returns 1; PENDING bit0 still 1; irq_o stays 0 until complete 1, then rises.
- Write ENABLE=0xFFFF_FFFF with be=4'b0001 -> ENABLE reads 0x000000FF for NumSrc=8; complete with ID 0 or ID 9 -> IN_SERVICE unchanged.
- Assert rst_i between a claim request and its response -> device_rvalid_o=0 in the next cycle; all registers read 0 after reset releases.

Source files
------------

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Memory-mapped interrupt aggregator. Latches up to NumSrc
//             peripheral interrupt lines (level or edge, per-source enable)
//             and drives a single request to the core. Software takes an
//             interrupt by reading CLAIM and retires it by writing its ID
//             back to CLAIM.
//  Ports    : clk_i, rst_i           - clock, async active-high reset
//             device_req_i/addr/we/be/wdata - single-cycle bus request
//             device_rvalid_o/rdata_o       - response, one cycle later
//             irq_src_i              - source lines, bit i is ID i+1
//             irq_o                  - aggregated registered request
//  Register map (addr[4:2]):
//             0 PENDING (RO), 1 ENABLE (RW), 2 EDGE_SEL (RW),
//             3 CLAIM (read=claim, write=complete), 4 IN_SERVICE (RO)
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int NumSrc    = 8,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   device_req_i,
  input  logic [AddrWidth-1:0]   device_addr_i,
  input  logic                   device_we_i,
  input  logic [DataWidth/8-1:0] device_be_i,
  input  logic [DataWidth-1:0]   device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [DataWidth-1:0]   device_rdata_o,
  input  logic [NumSrc-1:0]      irq_src_i,
  output logic                   irq_o
);

  // Register state
  logic [NumSrc-1:0]    r_pending;
  logic [NumSrc-1:0]    r_enable;
  logic [NumSrc-1:0]    r_edge_sel;
  logic [NumSrc-1:0]    r_in_service;
  logic [NumSrc-1:0]    r_src_q;
  logic                 r_irq;
  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;

  // Decode
  logic                 w_rd;
  logic                 w_wr;
  logic [2:0]           w_idx;
  logic                 w_claim;
  logic                 w_complete;
  logic [DataWidth-1:0] w_be_mask;
  logic [NumSrc-1:0]    w_be_n;
  logic [NumSrc-1:0]    w_wdata_n;
  logic [4:0]           w_cmp_id;
  logic [NumSrc-1:0]    w_cmp_oh;

  // Datapath
  logic [NumSrc-1:0]    w_cand;
  logic [NumSrc-1:0]    w_claim_oh;
  logic [4:0]           w_claim_id;
  logic [NumSrc-1:0]    w_rise;
  logic [NumSrc-1:0]    w_en_next;
  logic [NumSrc-1:0]    w_es_next;
  logic [NumSrc-1:0]    w_pend_next;
  logic [NumSrc-1:0]    w_isv_next;
  logic [DataWidth-1:0] w_rd_val;
  logic                 w_unused;

  assign w_rd       = device_req_i & ~device_we_i;
  assign w_wr       = device_req_i & device_we_i;
  assign w_idx      = device_addr_i[4:2];
  assign w_claim    = w_rd && (w_idx == 3'd3);
  assign w_complete = w_wr && (w_idx == 3'd3) && device_be_i[0];
  assign w_cmp_id   = device_wdata_i[4:0];

  // Only address bits [4:2] are decoded; wdata/byte-enable bits above the
  // implemented sources have no storage behind them.
  assign w_unused = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0],
                      device_wdata_i[DataWidth-1:NumSrc],
                      w_be_mask[DataWidth-1:NumSrc]};

  always_comb begin
    w_be_mask = '0;
    for (int b = 0; b < DataWidth / 8; b++) begin
      w_be_mask[b*8 +: 8] = {8{device_be_i[b]}};
    end
  end

  assign w_be_n    = w_be_mask[NumSrc-1:0];
  assign w_wdata_n = device_wdata_i[NumSrc-1:0];

  // One-hot decode of the ID written to CLAIM; IDs 0 and >NumSrc match nothing.
  always_comb begin
    w_cmp_oh = '0;
    for (int i = 0; i < NumSrc; i++) begin
      w_cmp_oh[i] = w_complete && (w_cmp_id == 5'(i + 1));
    end
  end

  // Claim candidates; lowest ID wins. x & -x isolates the lowest set bit.
  assign w_cand     = r_pending & r_enable & ~r_in_service;
  assign w_claim_oh = w_claim ? (w_cand & (~w_cand + 1'b1)) : '0;

  always_comb begin
    w_claim_id = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_claim_id = 5'(i + 1);
      end
    end
  end

  assign w_en_next = (w_wr && w_idx == 3'd1) ?
                     ((r_enable & ~w_be_n) | (w_wdata_n & w_be_n)) : r_enable;
  assign w_es_next = (w_wr && w_idx == 3'd2) ?
                     ((r_edge_sel & ~w_be_n) | (w_wdata_n & w_be_n)) : r_edge_sel;

  // Edge sources: a rise sets pending and beats a simultaneous claim clear.
  // Level sources: pending is a registered copy of the line. Any source whose
  // trigger mode changes this cycle starts again from a cleared pending bit.
  assign w_rise      = irq_src_i & ~r_src_q;
  assign w_pend_next = ((r_edge_sel & ((r_pending & ~w_claim_oh) | w_rise)) |
                        (~r_edge_sel & irq_src_i)) &
                       ~(w_es_next ^ r_edge_sel);
  assign w_isv_next  = (r_in_service | w_claim_oh) & ~w_cmp_oh;

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      3'd0:    w_rd_val[NumSrc-1:0] = r_pending;
      3'd1:    w_rd_val[NumSrc-1:0] = r_enable;
      3'd2:    w_rd_val[NumSrc-1:0] = r_edge_sel;
      3'd3:    w_rd_val[4:0]        = w_claim_id;
      3'd4:    w_rd_val[NumSrc-1:0] = r_in_service;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending    <= '0;
      r_enable     <= '0;
      r_edge_sel   <= '0;
      r_in_service <= '0;
      r_src_q      <= '0;
      r_irq        <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_src_q      <= irq_src_i;
      r_pending    <= w_pend_next;
      r_enable     <= w_en_next;
      r_edge_sel   <= w_es_next;
      r_in_service <= w_isv_next;
      r_irq        <= |w_cand;
      r_rvalid     <= device_req_i;
      r_rdata      <= w_rd ? w_rd_val : '0;
    end
  end

  assign device_rvalid_o = r_rvalid;
  assign device_rdata_o  = r_rdata;
  assign irq_o           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl. A per-source behavioural
//             model predicts bus responses (queued) and irq_o; a monitor
//             compares them against the DUT after every rising clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int N = 8;
  localparam logic [31:0] BASE = 32'h8000_5000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [3:0]    be = '0;
  logic [31:0]   wdata = '0;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [N-1:0]  src = '0;
  logic          irq;

  logic [N-1:0]  src_v = '0;

  // Reference model state
  logic [N-1:0]  m_pend, m_en, m_es, m_isv, m_srcq;
  logic          exp_rvalid = 1'b0;
  logic          exp_irq = 1'b0;
  logic [31:0]   exp_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NumSrc(N), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .irq_src_i      (src),
    .irq_o          (irq)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_es = '0; m_isv = '0; m_srcq = '0;
    exp_rvalid = 1'b0;
    exp_irq = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one clock given the inputs presented for that clock.
  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d,
                            input logic [N-1:0] s);
    logic [2:0]   idx;
    int           cid;
    logic [31:0]  rv, t;
    logic [N-1:0] n_en, n_es, n_pend, n_isv;
    logic         claimed, rise;
    int           id;
    idx = a[4:2];
    cid = 0;
    for (int i = 0; i < N; i++)
      if (cid == 0 && m_pend[i] && m_en[i] && !m_isv[i]) cid = i + 1;
    exp_irq = (cid != 0);
    case (idx)
      3'd0: rv = 32'(m_pend);
      3'd1: rv = 32'(m_en);
      3'd2: rv = 32'(m_es);
      3'd3: rv = 32'(cid);
      3'd4: rv = 32'(m_isv);
      default: rv = 32'd0;
    endcase
    n_en = m_en; n_es = m_es; n_isv = m_isv;
    if (r && w) begin
      if (idx == 3'd1) begin t = merge(32'(m_en), d, b); n_en = t[N-1:0]; end
      if (idx == 3'd2) begin t = merge(32'(m_es), d, b); n_es = t[N-1:0]; end
      if (idx == 3'd3 && b[0]) begin
        id = int'(d[4:0]);
        if (id >= 1 && id <= N) n_isv[id-1] = 1'b0;
      end
    end
    claimed = r && !w && idx == 3'd3 && cid != 0;
    if (claimed) n_isv[cid-1] = 1'b1;
    for (int i = 0; i < N; i++) begin
      rise = s[i] && !m_srcq[i];
      if (m_es[i]) n_pend[i] = (m_pend[i] && !(claimed && cid == i + 1)) || rise;
      else         n_pend[i] = s[i];
      if (n_es[i] != m_es[i]) n_pend[i] = 1'b0;
    end
    m_pend = n_pend; m_en = n_en; m_es = n_es; m_isv = n_isv; m_srcq = s;
    exp_rvalid = r;
    if (r) exp_q.push_back(w ? 32'd0 : rv);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d; src = src_v;
    model_step(r, w, a, b, d, src_v);
  endtask

  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    drive(r, w, a, b, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [3:0] b, input logic [31:0] d);
    cyc(1'b1, 1'b1, BASE + off, b, d);
  endtask

  task automatic rd(input logic [31:0] off);
    cyc(1'b1, 1'b0, BASE + off, 4'hF, 32'd0);
  endtask

  // Reset asserted mid-cycle, after the current inputs were presented.
  task automatic reset_now();
    #2;
    rst = 1'b1;
    req = 1'b0; we = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic read_all();
    for (int k = 0; k < 5; k++) rd(32'(k * 4));
  endtask

  // Monitor: compares DUT outputs against the model after each rising edge.
  logic [31:0] exp_d;
  always @(posedge clk) begin
    #1;
    checks++;
    if (rvalid !== exp_rvalid) begin
      errors++;
      $display("FAIL rvalid: got %b expected %b at %0t", rvalid, exp_rvalid, $time);
    end
    if (rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata: unexpected response %h at %0t", rdata, $time);
      end else begin
        exp_d = exp_q.pop_front();
        if (rdata !== exp_d) begin
          errors++;
          $display("FAIL rdata: got %h expected %h at %0t", rdata, exp_d, $time);
        end
      end
    end
    checks++;
    if (irq !== exp_irq) begin
      errors++;
      $display("FAIL irq_o: got %b expected %b at %0t", irq, exp_irq, $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r, w;
    logic [2:0]  ix;
    logic [31:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    // All registers zero after reset
    read_all();
    idle(2);

    // Edge source 3
    wr(32'h04, 4'hF, 32'h04);
    wr(32'h08, 4'hF, 32'h04);
    src_v[2] = 1'b1; idle(1);
    src_v[2] = 1'b0; idle(3);
    rd(32'h00); rd(32'h0C); rd(32'h00); rd(32'h10);
    idle(2);
    wr(32'h0C, 4'hF, 32'd3);
    rd(32'h10);
    idle(2);

    // Level sources 1 and 2
    wr(32'h08, 4'hF, 32'h00);
    wr(32'h04, 4'hF, 32'h03);
    src_v[1:0] = 2'b11; idle(3);
    rd(32'h0C); rd(32'h0C); rd(32'h0C);
    wr(32'h0C, 4'hF, 32'd1);
    idle(3);
    rd(32'h0C);
    wr(32'h0C, 4'hF, 32'd1);
    wr(32'h0C, 4'hF, 32'd2);
    src_v = '0; idle(3);

    // Claim coinciding with a fresh rising edge on the same source
    wr(32'h08, 4'hF, 32'h01);
    wr(32'h04, 4'hF, 32'h01);
    src_v[0] = 1'b1; idle(1);
    src_v[0] = 1'b0; idle(2);
    src_v[0] = 1'b1; rd(32'h0C);
    src_v[0] = 1'b0; idle(1);
    rd(32'h00);
    idle(3);
    wr(32'h0C, 4'hF, 32'd1);
    idle(3);
    rd(32'h0C);

    // Byte enables and illegal complete IDs
    wr(32'h04, 4'b0001, 32'hFFFF_FFFF);
    rd(32'h04);
    wr(32'h0C, 4'hF, 32'd0);
    wr(32'h0C, 4'hF, 32'd9);
    rd(32'h10);
    idle(2);

    // Reset between a claim request and its response
    src_v[0] = 1'b1; idle(1);
    src_v[0] = 1'b0; idle(2);
    wr(32'h0C, 4'hF, 32'd1);
    idle(2);
    rd(32'h0C);
    reset_now();
    read_all();
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) src_v[$urandom_range(0, N - 1)] ^= 1'b1;
      r  = ($urandom_range(0, 1) == 1);
      w  = ($urandom_range(0, 2) == 0);
      ix = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (ix == 3'd3 && w) d = 32'($urandom_range(0, 10));
      cyc(r, w, BASE | {27'd0, ix, 2'b00} | 32'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), d);
      if ($urandom_range(0, 299) == 0) reset_now();
    end

    src_v = '0;
    idle(4);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL response_count: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
